// File: rtl/image_src_arbiter_pkg.sv
// Shared image definitions: frame geometry, pixel width, arbiter state
// encoding and counter widths, also used by the Load_image block.
package image_src_arbiter_pkg;

   localparam int unsigned WIDTH_D   = 24;
   localparam int unsigned IMG_ROW   = 224;
   localparam int unsigned IMG_COL   = 224;
   localparam int unsigned IMG_SIZE  = IMG_ROW * IMG_COL;

   localparam int unsigned PIX_CNT_W = 16;
   localparam int unsigned GAP_CNT_W = 8;
   localparam int unsigned FRM_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_XFER  = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   typedef enum logic {
      SRC0 = 1'b0,
      SRC1 = 1'b1
   } src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; the last-served register is updated
// only while the frame-start state is active.
module rr_arb2
   import image_src_arbiter_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_upd,
   input  src_e i_served,
   output src_e o_pick
);

   src_e last_q;
   src_e last_d;

   always_comb begin
      last_d = last_q;
      if (i_upd) begin
         last_d = i_served;
      end
   end

   // Reset value "source 1 served last" lets source 0 win the first tie.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_q <= SRC1;
      end else begin
         last_q <= last_d;
      end
   end

   always_comb begin
      o_pick = SRC0;
      if (i_req0 && i_req1) begin
         o_pick = (last_q == SRC1) ? SRC0 : SRC1;
      end else if (i_req1) begin
         o_pick = SRC1;
      end
   end

endmodule

// File: rtl/image_src_arbiter.sv
// Frame-level arbiter between two pixel sources feeding one image loader:
// grants whole frames, forwards the owner's pixels, enforces an inter-frame gap.
module image_src_arbiter #(
   parameter int unsigned WIDTH_D = image_src_arbiter_pkg::WIDTH_D,
   parameter int unsigned IMG_ROW = image_src_arbiter_pkg::IMG_ROW,
   parameter int unsigned IMG_COL = image_src_arbiter_pkg::IMG_COL,
   parameter int unsigned GAP_CYC = 16
) (
   input  logic               i_sclk,
   input  logic               i_rstn,
   input  logic               i_req0,
   input  logic               i_req1,
   input  logic               i_vld0,
   input  logic               i_vld1,
   input  logic [WIDTH_D-1:0] i_data0,
   input  logic [WIDTH_D-1:0] i_data1,
   input  logic               i_abort,
   output logic               o_rdy0,
   output logic               o_rdy1,
   output logic               o_gnt0,
   output logic               o_gnt1,
   output logic               o_frame_rst,
   output logic               o_image_vld,
   output logic [WIDTH_D-1:0] o_image,
   output logic               o_busy,
   output logic [7:0]         o_frame_cnt
);

   import image_src_arbiter_pkg::*;

   localparam logic [PIX_CNT_W-1:0] LAST_IDX = PIX_CNT_W'(IMG_ROW * IMG_COL - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYC - 1);

   logic rst_meta_q;
   logic rst_sync_q;

   state_e               state_q,     state_d;
   src_e                 owner_q,     owner_d;
   logic [PIX_CNT_W-1:0] pix_cnt_q,   pix_cnt_d;
   logic [GAP_CNT_W-1:0] gap_cnt_q,   gap_cnt_d;
   logic [FRM_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                 gnt0_q,      gnt0_d;
   logic                 gnt1_q,      gnt1_d;
   logic                 frame_rst_q, frame_rst_d;
   logic                 image_vld_q, image_vld_d;
   logic [WIDTH_D-1:0]   image_q,     image_d;

   src_e               pick;
   logic               own_vld;
   logic [WIDTH_D-1:0] own_data;
   logic               accept;
   logic               start_st;

   // Release is seen two edges late; assertion still clears everything at once.
   always_ff @(posedge i_sclk or negedge i_rstn) begin
      if (!i_rstn) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   assign start_st = (state_q == ST_START);

   rr_arb2 u_rr_arb2 (
      .i_clk    (i_sclk),
      .i_rst_n  (i_rstn),
      .i_req0   (i_req0),
      .i_req1   (i_req1),
      .i_upd    (start_st),
      .i_served (owner_q),
      .o_pick   (pick)
   );

   always_comb begin
      own_vld  = i_vld0;
      own_data = i_data0;
      if (owner_q == SRC1) begin
         own_vld  = i_vld1;
         own_data = i_data1;
      end
   end

   assign accept = (state_q == ST_XFER) && own_vld;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      pix_cnt_d   = pix_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      frame_cnt_d = frame_cnt_q;
      gnt0_d      = gnt0_q;
      gnt1_d      = gnt1_q;
      frame_rst_d = 1'b0;
      image_vld_d = accept;
      image_d     = accept ? own_data : image_q;

      case (state_q)
         ST_IDLE: begin
            if (rst_sync_q && (i_req0 || i_req1)) begin
               owner_d     = pick;
               state_d     = ST_START;
               frame_rst_d = 1'b1;
               gnt0_d      = (pick == SRC0);
               gnt1_d      = (pick == SRC1);
            end
         end
         ST_START: begin
            pix_cnt_d = '0;
            if (i_abort) begin
               state_d     = ST_GAP;
               gap_cnt_d   = '0;
               frame_rst_d = 1'b1;
               gnt0_d      = 1'b0;
               gnt1_d      = 1'b0;
            end else begin
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (accept) begin
               pix_cnt_d = pix_cnt_q + 1'b1;
            end
            // Abort takes priority even when it lands on the final pixel.
            if (i_abort) begin
               state_d     = ST_GAP;
               gap_cnt_d   = '0;
               frame_rst_d = 1'b1;
               gnt0_d      = 1'b0;
               gnt1_d      = 1'b0;
            end else if (accept && (pix_cnt_q == LAST_IDX)) begin
               state_d     = ST_GAP;
               gap_cnt_d   = '0;
               frame_cnt_d = frame_cnt_q + 1'b1;
               gnt0_d      = 1'b0;
               gnt1_d      = 1'b0;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_sclk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= ST_IDLE;
         owner_q     <= SRC0;
         pix_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         frame_cnt_q <= '0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         frame_rst_q <= 1'b0;
         image_vld_q <= 1'b0;
         image_q     <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         pix_cnt_q   <= pix_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         frame_rst_q <= frame_rst_d;
         image_vld_q <= image_vld_d;
         image_q     <= image_d;
      end
   end

   assign o_rdy0      = (state_q == ST_XFER) && (owner_q == SRC0);
   assign o_rdy1      = (state_q == ST_XFER) && (owner_q == SRC1);
   assign o_gnt0      = gnt0_q;
   assign o_gnt1      = gnt1_q;
   assign o_frame_rst = frame_rst_q;
   assign o_image_vld = image_vld_q;
   assign o_image     = image_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_frame_cnt = frame_cnt_q;

endmodule
